alu: RTL and testbench

// - 32-bit registered ALU for the datapath execute stage.
// - Combines operands A and B under 4-bit opcode ALU_Sel into ALU_Out.
// - Also produces carry-out (coutfin) and zero (z) flags; all outputs registered.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_addsub.sv | 24 ++
 rtl/alu.sv | 99 +++++++++
 tb/tb_alu.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 32-bit registered ALU.
// Optional feature macro: ALU_OVF_EN (adds the registered signed-overflow output).
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_SLL  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_SRA  = 4'b1000,
      OP_SLTU = 4'b1001,
      OP_NOR  = 4'b1100
   } alu_op_e;

   localparam logic [ALU_W-1:0] ALU_OUT_RST = 32'h0;

endpackage

// File: rtl/alu_addsub.sv
// 32-bit adder/subtractor with carry-in, shared by ADD, SUB, SLT and SLTU.
// When sub is set the B operand is inverted and sub acts as the +1 carry-in,
// so carry is the no-borrow flag and ovf is signed overflow of A-B.
module alu_addsub
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic             sub,
   output logic [ALU_W-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   logic [ALU_W-1:0] b_eff;

   // Operand conditioning, add, and signed-overflow detection
   always_comb begin
      b_eff        = sub ? ~b : b;
      {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};
      ovf          = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
   end

endmodule

// File: rtl/alu.sv
// 32-bit registered ALU: opcode mux feeding one output/flag register.
// Optional feature macro: ALU_OVF_EN adds the registered ovf output
// (signed overflow for ADD/SUB, 0 otherwise).
module alu
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ALU_W-1:0] A,
   input  logic [ALU_W-1:0] B,
   input  logic [3:0]       ALU_Sel,
   output logic [ALU_W-1:0] ALU_Out,
   output logic             coutfin,
   output logic             z
`ifdef ALU_OVF_EN
   ,
   output logic             ovf
`endif
);

   alu_op_e          op;
   logic             as_sub;
   logic [ALU_W-1:0] as_sum;
   logic             as_carry;
   logic             as_ovf;
   logic [ALU_W-1:0] res_nxt;
   logic             cout_nxt;
`ifdef ALU_OVF_EN
   logic             ovf_nxt;
`endif

   assign op     = alu_op_e'(ALU_Sel);
   // SLT and SLTU are derived from A-B, so they share the subtract path
   assign as_sub = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);

   alu_addsub u_addsub (
      .a     (A),
      .b     (B),
      .sub   (as_sub),
      .sum   (as_sum),
      .carry (as_carry),
      .ovf   (as_ovf)
   );

   // Next-result mux; unused opcodes fall to zero with no carry
   always_comb begin
      res_nxt  = ALU_OUT_RST;
      cout_nxt = 1'b0;
`ifdef ALU_OVF_EN
      ovf_nxt  = 1'b0;
`endif
      unique case (op)
         OP_AND:  res_nxt = A & B;
         OP_OR:   res_nxt = A | B;
         OP_ADD: begin
            res_nxt  = as_sum;
            cout_nxt = as_carry;
`ifdef ALU_OVF_EN
            ovf_nxt  = as_ovf;
`endif
         end
         OP_XOR:  res_nxt = A ^ B;
         OP_SLL:  res_nxt = A << B[4:0];
         OP_SRL:  res_nxt = A >> B[4:0];
         OP_SUB: begin
            res_nxt  = as_sum;
            cout_nxt = as_carry;
`ifdef ALU_OVF_EN
            ovf_nxt  = as_ovf;
`endif
         end
         OP_SLT:  res_nxt = {{(ALU_W-1){1'b0}}, as_sum[ALU_W-1] ^ as_ovf};
         OP_SRA:  res_nxt = $unsigned($signed(A) >>> B[4:0]);
         OP_SLTU: res_nxt = {{(ALU_W-1){1'b0}}, ~as_carry};
         OP_NOR:  res_nxt = ~(A | B);
         default: res_nxt = ALU_OUT_RST;
      endcase
   end

   // Result and flags register together; z comes from the incoming result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALU_Out <= ALU_OUT_RST;
         coutfin <= 1'b0;
         z       <= 1'b1;
`ifdef ALU_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         ALU_Out <= res_nxt;
         coutfin <= cout_nxt;
         z       <= (res_nxt == '0);
`ifdef ALU_OVF_EN
         ovf     <= ovf_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, async reset behaviour,
// then randomized operations against an arithmetic reference model.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  ALU_Sel;
   logic [31:0] ALU_Out;
   logic        coutfin;
   logic        z;
`ifdef ALU_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int passed = 0;

   alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (A),
      .B       (B),
      .ALU_Sel (ALU_Sel),
      .ALU_Out (ALU_Out),
      .coutfin (coutfin),
      .z       (z)
`ifdef ALU_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Reference model from the opcode table, using wide/signed arithmetic
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] s, output logic [31:0] o,
                                 output logic c, output logic v);
      longint sa, sb, sr;
      logic [32:0] wide;
      logic [4:0]  sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = b[4:0];
      o = 32'h0; c = 1'b0; v = 1'b0;
      case (s)
         4'd0:  o = a & b;
         4'd1:  o = a | b;
         4'd2: begin
            wide = {1'b0, a} + {1'b0, b};
            o = wide[31:0]; c = wide[32];
            sr = sa + sb;
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd3:  o = a ^ b;
         4'd4:  o = a << sh;
         4'd5:  o = a >> sh;
         4'd6: begin
            o = a - b; c = (a >= b);
            sr = sa - sb;
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd7:  o = (sa < sb) ? 32'd1 : 32'd0;
         4'd8:  o = $unsigned($signed(a) >>> sh);
         4'd9:  o = (a < b) ? 32'd1 : 32'd0;
         4'd12: o = ~(a | b);
         default: o = 32'h0;
      endcase
   endfunction

   // Apply one operation at the falling edge; sample 1 ns after the next rising edge
   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
      @(negedge clk);
      A = a; B = b; ALU_Sel = s;
      @(posedge clk);
      #1;
   endtask

   // Directed vector with hand-written expectations
   task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] s, input logic [31:0] eo, input logic ec);
      apply(a, b, s);
      chk({tag, "_out"}, ALU_Out, eo);
      chk({tag, "_cout"}, {31'b0, coutfin}, {31'b0, ec});
      chk({tag, "_z"}, {31'b0, z}, {31'b0, (eo == 32'h0)});
   endtask

   // Randomized vector checked against the model
   task automatic rnd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
      logic [31:0] eo;
      logic ec, ev;
      model(a, b, s, eo, ec, ev);
      apply(a, b, s);
      chk("rand_out", ALU_Out, eo);
      chk("rand_cout", {31'b0, coutfin}, {31'b0, ec});
      chk("rand_z", {31'b0, z}, {31'b0, (eo == 32'h0)});
`ifdef ALU_OVF_EN
      chk("rand_ovf", {31'b0, ovf}, {31'b0, ev});
`endif
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] r;
      case ($urandom_range(0, 7))
         0: r = 32'h0;
         1: r = 32'hFFFF_FFFF;
         2: r = 32'h8000_0000;
         3: r = 32'h7FFF_FFFF;
         4: r = 32'(1 + $urandom_range(0, 31));
         default: r = $urandom;
      endcase
      return r;
   endfunction

   initial begin
      rst_n = 1'b0; A = 32'h0; B = 32'h0; ALU_Sel = 4'h0;
      #12;
      chk("rst_out", ALU_Out, 32'h0);
      chk("rst_cout", {31'b0, coutfin}, 32'h0);
      chk("rst_z", {31'b0, z}, 32'h1);
`ifdef ALU_OVF_EN
      chk("rst_ovf", {31'b0, ovf}, 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      dir("and12",  32'd1, 32'd2, 4'b0000, 32'd0, 1'b0);
      dir("or12",   32'd1, 32'd2, 4'b0001, 32'd3, 1'b0);
      dir("add12",  32'd1, 32'd2, 4'b0010, 32'd3, 1'b0);
      dir("add34",  32'd3, 32'd4, 4'b0010, 32'd7, 1'b0);
      dir("sub34",  32'd3, 32'd4, 4'b0110, 32'hFFFF_FFFF, 1'b0);
      dir("sub43",  32'd4, 32'd3, 4'b0110, 32'd1, 1'b1);
      dir("subeq",  32'd9, 32'd9, 4'b0110, 32'd0, 1'b1);
      dir("addwrap", 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1);
      dir("sra",    32'h8000_0000, 32'd4, 4'b1000, 32'hF800_0000, 1'b0);
      dir("srl",    32'h8000_0000, 32'd4, 4'b0101, 32'h0800_0000, 1'b0);
      dir("slt",    32'h8000_0000, 32'd1, 4'b0111, 32'd1, 1'b0);
      dir("sltu",   32'h8000_0000, 32'd1, 4'b1001, 32'd0, 1'b0);
      dir("sll",    32'h0000_0003, 32'hFFFF_FFE4, 4'b0100, 32'h0000_0030, 1'b0);
      dir("nor",    32'h0F0F_0000, 32'h0000_00F0, 4'b1100, 32'hF0F0_FF0F, 1'b0);
      dir("undef",  32'd3, 32'd4, 4'b1111, 32'd0, 1'b0);
      dir("undefa", 32'hFFFF_FFFF, 32'd1, 4'b1010, 32'd0, 1'b0);
`ifdef ALU_OVF_EN
      apply(32'h7FFF_FFFF, 32'd1, 4'b0010);
      chk("ovf_add", {31'b0, ovf}, 32'h1);
      apply(32'h8000_0000, 32'd1, 4'b0110);
      chk("ovf_sub", {31'b0, ovf}, 32'h1);
      apply(32'h7FFF_FFFF, 32'd1, 4'b0001);
      chk("ovf_or", {31'b0, ovf}, 32'h0);
`endif

      // Reset dropped between edges discards the registered ADD result at once
      apply(32'd3, 32'd4, 4'b0010);
      chk("pre_rst_out", ALU_Out, 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out", ALU_Out, 32'h0);
      chk("async_rst_z", {31'b0, z}, 32'h1);
      chk("async_rst_cout", {31'b0, coutfin}, 32'h0);
      @(posedge clk);
      #1;
      chk("held_rst_out", ALU_Out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_out", ALU_Out, 32'h0);
      @(posedge clk);
      #1;
      chk("resume_out", ALU_Out, 32'd7);
      chk("resume_z", {31'b0, z}, 32'h0);

      for (int i = 0; i < 300; i++) begin
         rnd(pick_operand(), pick_operand(), 4'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
